// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter with burst hold in front of a sync FIFO.
// Define FIFO_WR_ARB_STATS_EN to add the stall_cnt/grant_cnt statistics outputs.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       gnt,
  input  logic               fifo_full,
  input  logic               fifo_almost_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_in,
  output logic               busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [N*16-1:0]    grant_cnt
`endif
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_state_nx;
  logic [PW-1:0] r_ptr, w_ptr_nx, w_pick, w_gidx, w_j;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_data;
  logic r_wr_en, r_busy, w_space_ok, w_found, w_grant;
  // the registered write still in flight consumes the last free slot
  assign w_space_ok = !fifo_full && !(r_wr_en && fifo_almost_full);
  always_comb begin
    w_found = 1'b0;
    w_pick = r_ptr;
    w_j = r_ptr;
    for (int k = N; k >= 1; k--) begin
      w_j = PW'((int'(r_ptr) + k) % N);
      if (req[w_j]) begin
        w_found = 1'b1;
        w_pick = w_j;
      end
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx = r_ptr;
    w_cnt_nx = r_cnt;
    w_grant = 1'b0;
    w_gidx = r_ptr;
    if (r_state == IDLE) begin
      if (w_space_ok && w_found) begin
        w_grant = 1'b1;
        w_gidx = w_pick;
        w_ptr_nx = w_pick;
        w_cnt_nx = CW'(1);
        w_state_nx = BURST_LEN > 1 ? BURST : IDLE;
      end
    end else if (req[r_ptr] && r_cnt < CW'(BURST_LEN)) begin
      if (w_space_ok) begin
        w_grant = 1'b1;
        w_cnt_nx = r_cnt + 1'b1;
      end
    end else begin
      w_state_nx = IDLE;
    end
  end
  assign gnt = (w_grant && !rst) ? N'(1) << w_gidx : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= PW'(N - 1);
      r_cnt <= '0;
      r_wr_en <= 1'b0;
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr <= w_ptr_nx;
      r_cnt <= w_cnt_nx;
      r_wr_en <= w_grant;
      if (w_grant) r_data <= req_data[w_gidx*WIDTH +: WIDTH];
      r_busy <= w_state_nx == BURST;
    end
  end
  assign fifo_wr_en = r_wr_en;
  assign fifo_in = r_data;
  assign busy = r_busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stall;
  logic [N*16-1:0] r_gcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
      r_gcnt <= '0;
    end else begin
      if (|req && !w_space_ok && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
      for (int i = 0; i < N; i++)
        if (w_grant && w_gidx == PW'(i) && r_gcnt[i*16 +: 16] != 16'hFFFF)
          r_gcnt[i*16 +: 16] <= r_gcnt[i*16 +: 16] + 1'b1;
    end
  end
  assign stall_cnt = r_stall;
  assign grant_cnt = r_gcnt;
`endif
endmodule
